// File: rtl/prio_enc_rr_pkg.sv
// ============================================================================
// Module      : basic_chars_pkg
// Description : Shared constants for the basic_characters library blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package basic_chars_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage : basic_chars_pkg

`default_nettype wire

// File: rtl/prio_enc_rr_lsb.sv
// ============================================================================
// Module      : prio_lsb
// Description : Combinational lowest-set-bit finder (position, one-hot, any).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prio_lsb #(
    parameter int WIDTH = 8,
    parameter int POS_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [POS_W-1:0] pos,
    output logic [WIDTH-1:0] onehot,
    output logic             any
);

    always_comb begin
        onehot = vec & (~vec + WIDTH'(1));
        any    = |vec;
        pos    = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                pos = POS_W'(i);
            end
        end
    end

endmodule : prio_lsb

`default_nettype wire

// File: rtl/prio_enc_rr.sv
// ============================================================================
// Module      : prio_enc_rr
// Description : Registered fixed/round-robin priority encoder, valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prio_enc_rr
    import basic_chars_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int POS_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [POS_W-1:0] pos,
    output logic [WIDTH-1:0] onehot,
    output logic             none
);

    logic             r_out_valid;
    logic [POS_W-1:0] r_pos;
    logic [WIDTH-1:0] r_onehot;
    logic             r_none;
    logic [POS_W-1:0] r_ptr;

    logic             w_accept;
    logic [WIDTH-1:0] w_lowmask;
    logic [WIDTH-1:0] w_masked;
    logic [POS_W-1:0] w_m_pos;
    logic [WIDTH-1:0] w_m_onehot;
    logic             w_m_any;
    logic [POS_W-1:0] w_f_pos;
    logic [WIDTH-1:0] w_f_onehot;
    logic             w_f_any;
    logic [POS_W-1:0] w_pos;
    logic [WIDTH-1:0] w_onehot;
    logic [POS_W-1:0] w_ptr_nxt;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Round-robin window: only bits at or above the pointer.
    assign w_lowmask = (WIDTH'(1) << r_ptr) - WIDTH'(1);
    assign w_masked  = in & ~w_lowmask;

    prio_lsb #(.WIDTH(WIDTH), .POS_W(POS_W)) u_masked (
        .vec    (w_masked),
        .pos    (w_m_pos),
        .onehot (w_m_onehot),
        .any    (w_m_any)
    );

    prio_lsb #(.WIDTH(WIDTH), .POS_W(POS_W)) u_full (
        .vec    (in),
        .pos    (w_f_pos),
        .onehot (w_f_onehot),
        .any    (w_f_any)
    );

    // Masked search wraps to the unmasked search when nothing is above ptr.
    always_comb begin
        w_pos    = w_f_pos;
        w_onehot = w_f_onehot;
        if (mode == MODE_RR && w_m_any) begin
            w_pos    = w_m_pos;
            w_onehot = w_m_onehot;
        end
        w_ptr_nxt = (w_pos == POS_W'(WIDTH - 1)) ? '0 : w_pos + POS_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_pos       <= '0;
            r_onehot    <= '0;
            r_none      <= 1'b0;
            r_ptr       <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_pos       <= w_f_any ? w_pos : '0;
                r_onehot    <= w_onehot;
                r_none      <= !w_f_any;
                if (mode == MODE_RR && w_f_any) begin
                    r_ptr <= w_ptr_nxt;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign pos       = r_pos;
    assign onehot    = r_onehot;
    assign none      = r_none;

endmodule : prio_enc_rr

`default_nettype wire

// File: tb/tb_prio_enc_rr.sv
// ============================================================================
// Module      : tb_prio_enc_rr
// Description : Self-checking bench for prio_enc_rr at WIDTH=4 and WIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prio_enc_rr;

    typedef struct packed {
        logic [2:0] pos;
        logic [7:0] onehot;
        logic       none;
    } exp_t;

    logic       clk;
    logic       rst_n;

    logic       in_valid4, in_ready4, mode4, out_valid4, out_ready4, none4;
    logic [3:0] in4, onehot4;
    logic [1:0] pos4;

    logic       in_valid8, in_ready8, mode8, out_valid8, out_ready8, none8;
    logic [7:0] in8, onehot8;
    logic [2:0] pos8;

    int   n_pass;
    int   n_total;
    exp_t q4[$];
    exp_t q8[$];
    int   m_ptr4;
    int   m_ptr8;

    prio_enc_rr #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in(in4), .mode(mode4), .out_valid(out_valid4), .out_ready(out_ready4),
        .pos(pos4), .onehot(onehot4), .none(none4)
    );

    prio_enc_rr #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .in(in8), .mode(mode8), .out_valid(out_valid8), .out_ready(out_ready8),
        .pos(pos8), .onehot(onehot8), .none(none8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: linear circular scan, independent of the mask/fallback structure.
    function automatic exp_t model(input logic [7:0] vec, input int w, input logic md,
                                   input int ptr_in, output int ptr_out);
        exp_t e;
        bit   found;
        int   idx;
        e       = '0;
        found   = 1'b0;
        ptr_out = ptr_in;
        for (int k = 0; k < w; k++) begin
            idx = md ? (ptr_in + k) % w : k;
            if (!found && vec[idx]) begin
                found = 1'b1;
                e.pos = 3'(idx);
                if (md) ptr_out = (idx == w - 1) ? 0 : idx + 1;
            end
        end
        e.none   = !found;
        e.onehot = found ? (8'd1 << e.pos) : 8'd0;
        return e;
    endfunction

    // Drive one cycle on the 8-bit DUT; scoreboard pops on output handshake, pushes on accept.
    task automatic drive8(input bit v, input logic [7:0] vec, input logic md, input bit ordy);
        exp_t e;
        int   np;
        @(negedge clk);
        #2;
        in_valid8 = v; in8 = vec; mode8 = md; out_ready8 = ordy;
        #1;
        if (out_valid8 && out_ready8) begin
            n_total++;
            if (q8.size() == 0) begin
                $display("FAIL sb8: got pos=%0d onehot=%h none=%b, required no output", pos8, onehot8, none8);
            end else begin
                e = q8.pop_front();
                if ({pos8, onehot8, none8} !== {e.pos, e.onehot, e.none})
                    $display("FAIL sb8: got pos=%0d onehot=%h none=%b, required pos=%0d onehot=%h none=%b",
                             pos8, onehot8, none8, e.pos, e.onehot, e.none);
                else n_pass++;
            end
        end
        if (in_valid8 && in_ready8) begin
            q8.push_back(model(in8, 8, mode8, m_ptr8, np));
            m_ptr8 = np;
        end
    endtask

    task automatic drive4(input bit v, input logic [3:0] vec, input logic md, input bit ordy);
        exp_t e;
        int   np;
        @(negedge clk);
        #2;
        in_valid4 = v; in4 = vec; mode4 = md; out_ready4 = ordy;
        #1;
        if (out_valid4 && out_ready4) begin
            n_total++;
            if (q4.size() == 0) begin
                $display("FAIL sb4: got pos=%0d onehot=%b none=%b, required no output", pos4, onehot4, none4);
            end else begin
                e = q4.pop_front();
                if ({pos4, onehot4, none4} !== {e.pos[1:0], e.onehot[3:0], e.none})
                    $display("FAIL sb4: got pos=%0d onehot=%b none=%b, required pos=%0d onehot=%b none=%b",
                             pos4, onehot4, none4, e.pos[1:0], e.onehot[3:0], e.none);
                else n_pass++;
            end
        end
        if (in_valid4 && in_ready4) begin
            q4.push_back(model({4'b0, in4}, 4, mode4, m_ptr4, np));
            m_ptr4 = np;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid4 = 0; in4 = '0; mode4 = 0; out_ready4 = 0;
        in_valid8 = 0; in8 = '0; mode8 = 0; out_ready8 = 0;
        m_ptr4 = 0; m_ptr8 = 0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({out_valid8, pos8, onehot8, none8} !== 13'd0)
            $display("FAIL reset8_outs: got %b, required 0", {out_valid8, pos8, onehot8, none8});
        else n_pass++;
        n_total++;
        if (in_ready8 !== 1'b1) $display("FAIL reset8_in_ready: got %b, required 1", in_ready8);
        else n_pass++;
        n_total++;
        if ({out_valid4, pos4, onehot4, none4} !== 8'd0)
            $display("FAIL reset4_outs: got %b, required 0", {out_valid4, pos4, onehot4, none4});
        else n_pass++;
        n_total++;
        if (in_ready4 !== 1'b1) $display("FAIL reset4_in_ready: got %b, required 1", in_ready4);
        else n_pass++;
        #2 rst_n = 1'b1;
    endtask

    task automatic test_fixed_exhaustive();
        for (int v = 0; v <= 16; v++) begin
            drive4(v < 16, 4'(v), 1'b0, 1'b1);
            n_total++;
            if (in_ready4 !== 1'b1) $display("FAIL fixed4_in_ready: got %b, required 1", in_ready4);
            else n_pass++;
            if (v == 11) begin
                n_total++;
                if (pos4 !== 2'd1) $display("FAIL fixed4_1010: got %0d, required 1", pos4);
                else n_pass++;
            end
            if (v == 9) begin
                n_total++;
                if (pos4 !== 2'd3) $display("FAIL fixed4_1000: got %0d, required 3", pos4);
                else n_pass++;
            end
            if (v == 1) begin
                n_total++;
                if ({none4, pos4, onehot4} !== 7'b1_00_0000)
                    $display("FAIL fixed4_zero: got none=%b pos=%0d onehot=%b, required none=1 pos=0 onehot=0",
                             none4, pos4, onehot4);
                else n_pass++;
            end
        end
        drive4(1'b0, 4'd0, 1'b0, 1'b1);
    endtask

    task automatic test_rr_rotation();
        logic [2:0] exp_pos;
        for (int i = 0; i <= 10; i++) begin
            drive8(i < 10, 8'hFF, 1'b1, 1'b1);
            if (i > 0) begin
                exp_pos = 3'((i - 1) % 8);
                n_total++;
                if (out_valid8 !== 1'b1 || pos8 !== exp_pos || onehot8 !== (8'd1 << exp_pos))
                    $display("FAIL rr_rotation[%0d]: got valid=%b pos=%0d onehot=%h, required valid=1 pos=%0d onehot=%h",
                             i, out_valid8, pos8, onehot8, exp_pos, 8'd1 << exp_pos);
                else n_pass++;
            end
        end
        drive8(1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic test_rr_skip();
        drive8(1'b1, 8'h04, 1'b1, 1'b1);
        drive8(1'b1, 8'h05, 1'b1, 1'b1);
        n_total++;
        if (pos8 !== 3'd2) $display("FAIL rr_setptr3: got %0d, required 2", pos8);
        else n_pass++;
        drive8(1'b1, 8'h05, 1'b1, 1'b1);
        n_total++;
        if (pos8 !== 3'd0) $display("FAIL rr_skip_wrap: got %0d, required 0", pos8);
        else n_pass++;
        drive8(1'b0, 8'h00, 1'b1, 1'b1);
        n_total++;
        if (pos8 !== 3'd2) $display("FAIL rr_skip_next: got %0d, required 2", pos8);
        else n_pass++;
    endtask

    task automatic test_zero_rr();
        drive8(1'b1, 8'h10, 1'b1, 1'b1);
        drive8(1'b1, 8'h00, 1'b1, 1'b1);
        n_total++;
        if (pos8 !== 3'd4) $display("FAIL rr_setptr5: got %0d, required 4", pos8);
        else n_pass++;
        drive8(1'b1, 8'hFF, 1'b1, 1'b1);
        n_total++;
        if ({none8, pos8, onehot8} !== {1'b1, 3'd0, 8'h00})
            $display("FAIL rr_zero: got none=%b pos=%0d onehot=%h, required none=1 pos=0 onehot=00", none8, pos8, onehot8);
        else n_pass++;
        drive8(1'b0, 8'h00, 1'b1, 1'b1);
        n_total++;
        if (pos8 !== 3'd5 || none8 !== 1'b0) $display("FAIL rr_after_zero: got pos=%0d none=%b, required pos=5 none=0", pos8, none8);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        drive8(1'b1, 8'h0C, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive8(1'b1, 8'h30, 1'b0, 1'b0);
            n_total++;
            if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0 || pos8 !== 3'd2 || onehot8 !== 8'h04)
                $display("FAIL hold[%0d]: got valid=%b in_ready=%b pos=%0d onehot=%h, required valid=1 in_ready=0 pos=2 onehot=04",
                         i, out_valid8, in_ready8, pos8, onehot8);
            else n_pass++;
        end
        drive8(1'b1, 8'h30, 1'b0, 1'b1);
        n_total++;
        if (in_ready8 !== 1'b1 || pos8 !== 3'd2) $display("FAIL release: got in_ready=%b pos=%0d, required in_ready=1 pos=2", in_ready8, pos8);
        else n_pass++;
        drive8(1'b1, 8'h80, 1'b0, 1'b1);
        n_total++;
        if (out_valid8 !== 1'b1 || pos8 !== 3'd4) $display("FAIL replace: got valid=%b pos=%0d, required valid=1 pos=4", out_valid8, pos8);
        else n_pass++;
        drive8(1'b0, 8'h00, 1'b0, 1'b1);
        n_total++;
        if (out_valid8 !== 1'b1 || pos8 !== 3'd7) $display("FAIL b2b_last: got valid=%b pos=%0d, required valid=1 pos=7", out_valid8, pos8);
        else n_pass++;
        drive8(1'b0, 8'h00, 1'b0, 1'b1);
        n_total++;
        if (out_valid8 !== 1'b0) $display("FAIL drain: got valid=%b, required 0", out_valid8);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        drive8(1'b1, 8'h02, 1'b0, 1'b1);
        drive8(1'b0, 8'h00, 1'b0, 1'b0);
        n_total++;
        if (out_valid8 !== 1'b1 || pos8 !== 3'd1) $display("FAIL pre_reset: got valid=%b pos=%0d, required valid=1 pos=1", out_valid8, pos8);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({out_valid8, pos8, onehot8, none8} !== 13'd0)
            $display("FAIL async_reset: got %b, required 0", {out_valid8, pos8, onehot8, none8});
        else n_pass++;
        q4.delete(); q8.delete();
        m_ptr4 = 0; m_ptr8 = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        drive8(1'b1, 8'hFF, 1'b1, 1'b1);
        drive8(1'b0, 8'h00, 1'b1, 1'b1);
        n_total++;
        if (out_valid8 !== 1'b1 || pos8 !== 3'd0) $display("FAIL post_reset_rr: got valid=%b pos=%0d, required valid=1 pos=0", out_valid8, pos8);
        else n_pass++;
        drive8(1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_fixed_exhaustive();
        test_rr_rotation();
        test_rr_skip();
        test_zero_rr();
        test_back_to_back();
        test_async_reset();
        n_total++;
        if (q8.size() != 0 || q4.size() != 0)
            $display("FAIL sb_leftover: got %0d/%0d pending, required 0/0", q8.size(), q4.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_prio_enc_rr

`default_nettype wire
